// File: rtl/board_mm_master.sv
// board_mm_master: Avalon-MM master that moves a run of words between the control block's
// slave RAM and local streams, with one bus transfer outstanding at a time.
//
// A command (cmd_write, cmd_address, cmd_length) is accepted on cmd_start while idle.
//   write: each word is taken from the src stream, then written to the slave.
//   read : each word is fetched from the slave, then presented on the dst stream.
// cmd_busy is high outside IDLE; cmd_done pulses for one cycle when the run completes.
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   cmd_*                       command interface (start, write, address, length, busy, done)
//   master_*                    Avalon-MM master (address, read, write, writedata, byteenable,
//                               readdata, waitrequest, readdatavalid)
//   src_data/valid/ready        write-source stream (master is the sink)
//   dst_data/valid/ready        read-result stream (master is the source)
module board_mm_master #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned LEN_WIDTH  = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_start,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_address,
    input  logic [LEN_WIDTH-1:0]    cmd_length,
    output logic                    cmd_busy,
    output logic                    cmd_done,
    output logic [ADDR_WIDTH-1:0]   master_address,
    output logic                    master_read,
    output logic                    master_write,
    output logic [DATA_WIDTH-1:0]   master_writedata,
    output logic [DATA_WIDTH/8-1:0] master_byteenable,
    input  logic [DATA_WIDTH-1:0]   master_readdata,
    input  logic                    master_waitrequest,
    input  logic                    master_readdatavalid,
    input  logic [DATA_WIDTH-1:0]   src_data,
    input  logic                    src_valid,
    output logic                    src_ready,
    output logic [DATA_WIDTH-1:0]   dst_data,
    output logic                    dst_valid,
    input  logic                    dst_ready
);

    typedef enum logic [2:0] {
        StIdle,
        StWrFetch,
        StWrReq,
        StRdReq,
        StRdWait,
        StRdPush,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            rem_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        master_read  = 1'b0;
        master_write = 1'b0;
        src_ready    = 1'b0;
        dst_valid    = 1'b0;
        cmd_done     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_start) begin
                    addr_d = cmd_address;
                    rem_d  = cmd_length;
                    if (cmd_length == '0) begin
                        state_d = StDone;
                    end else if (cmd_write) begin
                        state_d = StWrFetch;
                    end else begin
                        state_d = StRdReq;
                    end
                end
            end
            StWrFetch: begin
                src_ready = 1'b1;
                if (src_valid) begin
                    wdata_d = src_data;
                    state_d = StWrReq;
                end
            end
            StWrReq: begin
                master_write = 1'b1;
                if (!master_waitrequest) begin
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    rem_d   = rem_q - LEN_WIDTH'(1);
                    state_d = (rem_q == LEN_WIDTH'(1)) ? StDone : StWrFetch;
                end
            end
            StRdReq: begin
                master_read = 1'b1;
                if (!master_waitrequest) begin
                    // A zero-latency slave returns data in the acceptance cycle itself.
                    if (master_readdatavalid) begin
                        rdata_d = master_readdata;
                        state_d = StRdPush;
                    end else begin
                        state_d = StRdWait;
                    end
                end
            end
            StRdWait: begin
                if (master_readdatavalid) begin
                    rdata_d = master_readdata;
                    state_d = StRdPush;
                end
            end
            StRdPush: begin
                dst_valid = 1'b1;
                if (dst_ready) begin
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    rem_d   = rem_q - LEN_WIDTH'(1);
                    state_d = (rem_q == LEN_WIDTH'(1)) ? StDone : StRdReq;
                end
            end
            StDone: begin
                cmd_done = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign cmd_busy          = (state_q != StIdle);
    assign master_address    = addr_q;
    assign master_writedata  = wdata_q;
    assign dst_data          = rdata_q;
    assign master_byteenable = (master_read || master_write) ? '1 : '0;

endmodule

// File: tb/tb_board_mm_master.sv
module tb_board_mm_master;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 15;
    localparam int unsigned LW = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_start = 1'b0;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_address = '0;
    logic [LW-1:0] cmd_length = '0;
    logic          cmd_busy, cmd_done;
    logic [AW-1:0] master_address;
    logic          master_read, master_write;
    logic [DW-1:0] master_writedata;
    logic [DW/8-1:0] master_byteenable;
    logic [DW-1:0] master_readdata = '0;
    logic          master_waitrequest = 1'b0;
    logic          master_readdatavalid = 1'b0;
    logic [DW-1:0] src_data = '0;
    logic          src_valid = 1'b0;
    logic          src_ready;
    logic [DW-1:0] dst_data;
    logic          dst_valid;
    logic          dst_ready = 1'b1;

    board_mm_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk                  (clk),
        .reset                (reset),
        .cmd_start            (cmd_start),
        .cmd_write            (cmd_write),
        .cmd_address          (cmd_address),
        .cmd_length           (cmd_length),
        .cmd_busy             (cmd_busy),
        .cmd_done             (cmd_done),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_write         (master_write),
        .master_writedata     (master_writedata),
        .master_byteenable    (master_byteenable),
        .master_readdata      (master_readdata),
        .master_waitrequest   (master_waitrequest),
        .master_readdatavalid (master_readdatavalid),
        .src_data             (src_data),
        .src_valid            (src_valid),
        .src_ready            (src_ready),
        .dst_data             (dst_data),
        .dst_valid            (dst_valid),
        .dst_ready            (dst_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected-transaction model: what the bus and dst stream must show, in order.
    logic [AW-1:0] exp_wr_addr[$];
    logic [DW-1:0] exp_wr_data[$];
    logic [AW-1:0] exp_rd_addr[$];
    logic [DW-1:0] exp_dst[$];
    logic [DW-1:0] src_q[$];
    // What actually happened, for literal spot checks.
    logic [AW-1:0] wr_log_addr[$];
    logic [DW-1:0] wr_log_data[$];
    logic [AW-1:0] rd_log[$];
    logic [DW-1:0] dst_log[$];
    int done_cnt = 0;
    int wr_cycles = 0;

    // Slave / stream environment controls.
    int wr_stall = 0;
    int dst_hold = 0;
    bit lat0 = 1'b0;

    function automatic logic [DW-1:0] ram_val(input logic [AW-1:0] a);
        return 32'hDEAD0000 ^ {17'b0, a};
    endfunction

    task automatic expect_write(input logic [AW-1:0] a, input int n, input logic [DW-1:0] d0);
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] ai;
            ai = a + AW'(i);
            exp_wr_addr.push_back(ai);
            exp_wr_data.push_back(d0 + DW'(i));
            src_q.push_back(d0 + DW'(i));
        end
    endtask

    task automatic expect_read(input logic [AW-1:0] a, input int n);
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] ai;
            ai = a + AW'(i);
            exp_rd_addr.push_back(ai);
            exp_dst.push_back(ram_val(ai));
        end
    endtask

    task automatic clear_logs();
        wr_log_addr.delete();
        wr_log_data.delete();
        rd_log.delete();
        dst_log.delete();
        wr_cycles = 0;
    endtask

    // waitrequest stalls and dst back-pressure
    initial forever begin
        @(posedge clk);
        #1;
        if ((master_read || master_write) && wr_stall > 0) begin
            master_waitrequest = 1'b1;
            wr_stall--;
        end else begin
            master_waitrequest = 1'b0;
        end
        if (dst_valid && dst_hold > 0) begin
            dst_ready = 1'b0;
            dst_hold--;
        end else begin
            dst_ready = 1'b1;
        end
    end

    // Source stream
    initial begin
        bit take;
        forever begin
            @(negedge clk);
            take = src_valid && src_ready;
            @(posedge clk);
            #1;
            if (take) void'(src_q.pop_front());
            src_valid = (src_q.size() > 0);
            src_data  = (src_q.size() > 0) ? src_q[0] : '0;
        end
    end

    // Slave read responses (latency 0 or 1)
    initial begin
        bit            pend = 1'b0;
        logic [AW-1:0] pend_addr = '0;
        forever begin
            @(posedge clk);
            #2;
            master_readdatavalid = 1'b0;
            if (!reset) pend = 1'b0;
            if (pend) begin
                master_readdatavalid = 1'b1;
                master_readdata      = ram_val(pend_addr);
                pend                 = 1'b0;
            end
            if (reset && master_read && !master_waitrequest) begin
                if (lat0) begin
                    master_readdatavalid = 1'b1;
                    master_readdata      = ram_val(master_address);
                end else begin
                    pend      = 1'b1;
                    pend_addr = master_address;
                end
            end
        end
    end

    // Compare process
    initial begin
        bit            prev_stall = 1'b0;
        bit            prev_hold = 1'b0;
        logic [AW-1:0] p_addr = '0;
        logic [1:0]    p_req = '0;
        logic [DW-1:0] p_wdata = '0;
        logic [DW-1:0] p_dst = '0;
        int            outstanding = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_stall  = 1'b0;
                prev_hold   = 1'b0;
                outstanding = 0;
            end else begin
                check("byteenable", master_byteenable,
                      (master_read || master_write) ? 64'hF : 64'h0);
                check("rd_wr_exclusive", master_read && master_write, 1'b0);
                if (master_read) check("read_while_data_pending", outstanding, 0);
                if (prev_stall) begin
                    check("stall_addr", master_address, p_addr);
                    check("stall_req", {master_read, master_write}, p_req);
                    if (p_req[0]) check("stall_wdata", master_writedata, p_wdata);
                end
                if (prev_hold) begin
                    check("hold_valid", dst_valid, 1'b1);
                    check("hold_data", dst_data, p_dst);
                end
                if (master_write) wr_cycles++;
                if (master_write && !master_waitrequest) begin
                    wr_log_addr.push_back(master_address);
                    wr_log_data.push_back(master_writedata);
                    if (exp_wr_addr.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_write: got addr %0h, expected none", master_address);
                    end else begin
                        check("wr_addr", master_address, exp_wr_addr.pop_front());
                        check("wr_data", master_writedata, exp_wr_data.pop_front());
                    end
                end
                if (master_read && !master_waitrequest) begin
                    rd_log.push_back(master_address);
                    outstanding++;
                    if (exp_rd_addr.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_read: got addr %0h, expected none", master_address);
                    end else begin
                        check("rd_addr", master_address, exp_rd_addr.pop_front());
                    end
                end
                if (dst_valid && dst_ready) begin
                    dst_log.push_back(dst_data);
                    outstanding--;
                    if (exp_dst.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_dst: got %0h, expected none", dst_data);
                    end else begin
                        check("dst_data", dst_data, exp_dst.pop_front());
                    end
                end
                if (cmd_done) done_cnt++;
                prev_stall = (master_read || master_write) && master_waitrequest;
                p_addr     = master_address;
                p_req      = {master_read, master_write};
                p_wdata    = master_writedata;
                prev_hold  = dst_valid && !dst_ready;
                p_dst      = dst_data;
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, cmd_busy, 1'b0);
        check({tag, "_done"}, cmd_done, 1'b0);
        check({tag, "_addr"}, master_address, 0);
        check({tag, "_rw"}, {master_read, master_write}, 2'b00);
        check({tag, "_wdata"}, master_writedata, 0);
        check({tag, "_be"}, master_byteenable, 0);
        check({tag, "_src_ready"}, src_ready, 1'b0);
        check({tag, "_dst"}, {dst_valid, dst_data}, 0);
    endtask

    task automatic run_cmd(input bit w, input logic [AW-1:0] a, input logic [LW-1:0] n);
        @(posedge clk);
        #1;
        cmd_start   = 1'b1;
        cmd_write   = w;
        cmd_address = a;
        cmd_length  = n;
        @(posedge clk);
        #1;
        cmd_start = 1'b0;
    endtask

    // Waits for the done pulse, then checks it was single and busy dropped after it.
    task automatic wait_done(input string tag);
        int start_cnt;
        int cyc;
        start_cnt = done_cnt;
        cyc = 0;
        while (done_cnt == start_cnt && cyc < 300) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check({tag, "_done_seen"}, done_cnt, start_cnt + 1);
        check({tag, "_busy_in_done"}, cmd_busy, 1'b1);
        @(negedge clk);
        #1;
        check({tag, "_busy_after"}, cmd_busy, 1'b0);
        check({tag, "_done_once"}, done_cnt, start_cnt + 1);
        check({tag, "_exp_empty"},
              exp_wr_addr.size() + exp_rd_addr.size() + exp_dst.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        int cyc;

        // Reset state
        @(negedge clk);
        check_outputs_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check_outputs_zero("idle");

        // 1: 4-word write, no stalls
        clear_logs();
        expect_write(15'h0010, 4, 32'hA0);
        run_cmd(1'b1, 15'h0010, 15'd4);
        wait_done("t1");
        check("t1_nwr", wr_log_addr.size(), 4);
        check("t1_addr0", wr_log_addr[0], 15'h0010);
        check("t1_addr3", wr_log_addr[3], 15'h0013);
        check("t1_data3", wr_log_data[3], 32'hA3);

        // 2: 3-word read, latency 1
        clear_logs();
        lat0 = 1'b0;
        expect_read(15'h0100, 3);
        run_cmd(1'b0, 15'h0100, 15'd3);
        wait_done("t2");
        check("t2_nrd", rd_log.size(), 3);
        check("t2_dst0", dst_log[0], 32'hDEAD0100);
        check("t2_dst2", dst_log[2], 32'hDEAD0102);

        // 3: 1-word write, waitrequest high 5 cycles
        clear_logs();
        wr_stall = 5;
        expect_write(15'h0200, 1, 32'h12345678);
        run_cmd(1'b1, 15'h0200, 15'd1);
        wait_done("t3");
        check("t3_wr_cycles", wr_cycles, 6);
        check("t3_nwr", wr_log_addr.size(), 1);
        check("t3_data", wr_log_data[0], 32'h12345678);

        // 4: 2-word read across the address wrap, dst held off 3 cycles, zero-latency slave
        clear_logs();
        lat0 = 1'b1;
        dst_hold = 3;
        expect_read(15'h7FFF, 2);
        run_cmd(1'b0, 15'h7FFF, 15'd2);
        wait_done("t4");
        check("t4_addr0", rd_log[0], 15'h7FFF);
        check("t4_addr1", rd_log[1], 15'h0000);
        check("t4_dst0", dst_log[0], 32'hDEAD7FFF);
        check("t4_dst1", dst_log[1], 32'hDEAD0000);
        lat0 = 1'b0;

        // 5a: zero-length command
        clear_logs();
        d0 = done_cnt;
        @(posedge clk);
        #1;
        cmd_start   = 1'b1;
        cmd_write   = 1'b1;
        cmd_address = 15'h0033;
        cmd_length  = '0;
        @(negedge clk);
        check("t5a_no_done_yet", cmd_done, 1'b0);
        @(posedge clk);
        #1;
        cmd_start = 1'b0;
        @(negedge clk);
        check("t5a_done_next", cmd_done, 1'b1);
        check("t5a_busy_in_done", cmd_busy, 1'b1);
        @(negedge clk);
        check("t5a_busy_after", cmd_busy, 1'b0);
        check("t5a_bus_quiet", wr_cycles + rd_log.size(), 0);
        #1;
        check("t5a_done_cnt", done_cnt, d0 + 1);

        // 5b: cmd_start while busy is ignored
        clear_logs();
        wr_stall = 3;
        expect_write(15'h0020, 2, 32'hB0);
        run_cmd(1'b1, 15'h0020, 15'd2);
        @(posedge clk);
        #1;
        cmd_start   = 1'b1;
        cmd_write   = 1'b0;
        cmd_address = 15'h0040;
        cmd_length  = 15'd5;
        repeat (2) @(posedge clk);
        #1;
        cmd_start = 1'b0;
        wait_done("t5b");
        check("t5b_nwr", wr_log_addr.size(), 2);
        check("t5b_data1", wr_log_data[1], 32'hB1);
        check("t5b_nrd", rd_log.size(), 0);

        // 6: reset while waiting for read data
        clear_logs();
        d0 = done_cnt;
        expect_read(15'h0300, 4);
        run_cmd(1'b0, 15'h0300, 15'd4);
        cyc = 0;
        while (rd_log.size() == 0 && cyc < 50) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("t6_first_read", rd_log.size(), 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_outputs_zero("t6_async");
        exp_rd_addr.delete();
        exp_dst.delete();
        @(negedge clk);
        check_outputs_zero("t6_held");
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_no_done", done_cnt, d0);
        check("t6_idle", cmd_busy, 1'b0);
        check("t6_no_more_reads", rd_log.size(), 1);

        // 6b: normal write after the abort
        clear_logs();
        expect_write(15'h0050, 1, 32'hC0);
        run_cmd(1'b1, 15'h0050, 15'd1);
        wait_done("t6b");
        check("t6b_addr", wr_log_addr[0], 15'h0050);
        check("t6b_data", wr_log_data[0], 32'hC0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/board_mm_master.md
Name: board_mm_master

Overview:
- Avalon-MM master that drives the control block's slave port: the initiator end of that slave interface.
- A command (direction, start word address, length) moves a run of words between the slave RAM and local streams.
- Write commands take words from a source stream and write them to the slave. Read commands fetch words from the slave and present them on a sink stream.
- Sits between the search/board-update logic and the control block's RAM; one transfer outstanding at a time.

Parameters:
DATA_WIDTH, 32, word width of the Avalon data bus and both streams
ADDR_WIDTH, 15, word-address width; matches the control block's slave address
LEN_WIDTH, 15, width of the command length field, in words

Ports:
clk  in  1  system clock, all logic rising-edge
reset  in  1  asynchronous, active-low reset (0 = reset)
cmd_start  in  1  start pulse; sampled only in IDLE
cmd_write  in  1  1 = write to slave, 0 = read from slave
cmd_address  in  ADDR_WIDTH  first word address
cmd_length  in  LEN_WIDTH  number of words; 0 = no-op
cmd_busy  out  1  high in every state except IDLE
cmd_done  out  1  one-cycle completion pulse
master_address  out  ADDR_WIDTH  current word address
master_read  out  1  Avalon read request
master_write  out  1  Avalon write request
master_writedata  out  DATA_WIDTH  write data
master_byteenable  out  DATA_WIDTH/8  all ones while read or write is asserted, else 0
master_readdata  in  DATA_WIDTH  read data
master_waitrequest  in  1  slave stall
master_readdatavalid  in  1  read data valid
src_data  in  DATA_WIDTH  write-source word
src_valid  in  1  source word available
src_ready  out  1  master accepts source word
dst_data  out  DATA_WIDTH  read-result word
dst_valid  out  1  result word available
dst_ready  in  1  consumer accepts result word

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - All outputs are 0.
  - Address, remaining-count and data registers are cleared.
  - Reset mid-command aborts it immediately, with no cmd_done pulse and no further bus cycles.
- FSM states: IDLE, WR_FETCH, WR_REQ, RD_REQ, RD_WAIT, RD_PUSH, DONE.
- IDLE:
  - On cmd_start=1, latch cmd_address into addr and cmd_length into rem.
  - If cmd_length=0, go to DONE.
  - Otherwise go to WR_FETCH if cmd_write=1, else RD_REQ.
  - cmd_start is ignored in all other states.
- WR_FETCH:
  - src_ready=1.
  - On src_valid=1, latch src_data into master_writedata and go to WR_REQ.
  - src_ready is 0 in every other state.
- WR_REQ:
  - master_write=1, master_address=addr; address and data are held stable while master_waitrequest=1.
  - On the first cycle with master_waitrequest=0 the write is accepted: addr<=addr+1, rem<=rem-1.
  - Then go to DONE if rem was 1, else WR_FETCH.
  - Minimum throughput is 2 cycles per word.
- RD_REQ:
  - master_read=1, master_address=addr, held while master_waitrequest=1.
  - On acceptance (waitrequest=0), go to RD_WAIT.
  - If master_readdatavalid=1 in the acceptance cycle (zero-latency slave), capture master_readdata and go straight to RD_PUSH.
- RD_WAIT:
  - master_read=0.
  - On master_readdatavalid=1, capture master_readdata into dst_data and go to RD_PUSH.
  - No timeout.
- RD_PUSH:
  - dst_valid=1; dst_data is stable until accepted.
  - On dst_ready=1: addr<=addr+1, rem<=rem-1, then DONE if rem was 1, else RD_REQ.
- readdatavalid outside RD_REQ/RD_WAIT is ignored; readdata is never captured there.
- DONE: cmd_done=1 for exactly one cycle, then IDLE. cmd_busy is still 1 in DONE.
- Address arithmetic: modulo 2^ADDR_WIDTH, so the last address wraps to 0 without error.
- rem is LEN_WIDTH bits; max transfer is 2^LEN_WIDTH-1 words.
- master_read and master_write are never asserted together.
- No new request is issued before the previous read's data has been pushed.

Test Plan:
1. Write 4 words to addr 0x0010, src supplies 0xA0..0xA3 every cycle, waitrequest=0 -> writes to 0x0010..0x0013 with data 0xA0..0xA3, byteenable=4'hF; cmd_done pulses once; cmd_busy returns to 0 the cycle after done.
2. Read 3 words from 0x0100, slave latency 1 (readdatavalid the cycle after acceptance), dst_ready=1 -> dst_data sequence equals slave RAM[0x0100..0x0102]; master_read is high for exactly 3 accepted cycles.
3. Write 1 word with waitrequest held high for 5 cycles -> master_write, address and writedata are stable for 6 cycles; exactly one write is accepted; rem reaches 0; done pulses.
4. Read 2 words from 0x7FFF -> addresses 0x7FFF then 0x0000 (wrap); dst_ready low for 3 cycles on the first word holds dst_valid/dst_data stable and no second read is issued.
5. cmd_length=0 with cmd_start -> no bus activity; cmd_done pulses one cycle later. cmd_start asserted while busy -> ignored; the current command completes unchanged.
6. reset driven low in RD_WAIT during a 4-word read -> all outputs 0 immediately with no done pulse; after release a new 1-word write completes normally.
